// File: rtl/core_mem_arb_pkg.sv
// Shared types for the core memory arbiter: FSM state encoding
// and the strobe-width helper used by the top-level port list.
package core_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_e;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/core_mem_arb_pick.sv
// Combinational winner select for the arbiter's IDLE state.
// Ports: imem_valid_i, dmem_valid_i, [last_owner_i], pick_o (next owner).
// CORE_MEM_ARB_RR_EN: adds last_owner_i (1 = dmem) and round-robin ties.
module core_mem_arb_pick
  import core_mem_arb_pkg::*;
(
  input  logic       imem_valid_i,
  input  logic       dmem_valid_i,
`ifdef CORE_MEM_ARB_RR_EN
  input  logic       last_owner_i,
`endif
  output arb_state_e pick_o
);

  logic take_d;

`ifdef CORE_MEM_ARB_RR_EN
  // On a tie, dmem wins only if imem was served last.
  assign take_d = dmem_valid_i &
                  (~imem_valid_i | ~last_owner_i);
`else
  assign take_d = dmem_valid_i;
`endif

  always_comb begin
    pick_o = IDLE;
    if (take_d) begin
      pick_o = OWN_D;
    end else if (imem_valid_i) begin
      pick_o = OWN_I;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory bus port between instruction fetch (imem) and
// load/store (dmem) with a registered grant held until handshake.
// Ports: clk, rst (sync, active high); imem_* and dmem_* requester
// ports; mem_* bus port; grant_d = current owner is dmem.
// CORE_MEM_ARB_RR_EN: round-robin on ties instead of dmem priority.
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      imem_valid,
  output logic                      imem_ready,
  input  logic [ADDR_W-1:0]         imem_addr,
  output logic [DATA_W-1:0]         imem_rdata,
  input  logic                      dmem_valid,
  output logic                      dmem_ready,
  input  logic [ADDR_W-1:0]         dmem_addr,
  input  logic                      dmem_write,
  input  logic [DATA_W-1:0]         dmem_wdata,
  input  logic [strb_w(DATA_W)-1:0] dmem_wstrb,
  output logic [DATA_W-1:0]         dmem_rdata,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_write,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [strb_w(DATA_W)-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      grant_d
);

  localparam int STRB_W = strb_w(DATA_W);

  arb_state_e state_q;
  arb_state_e state_d;
  arb_state_e pick;

`ifdef CORE_MEM_ARB_RR_EN
  logic last_owner_q;
  logic last_owner_d;
`endif

  core_mem_arb_pick u_pick (
    .imem_valid_i (imem_valid),
    .dmem_valid_i (dmem_valid),
`ifdef CORE_MEM_ARB_RR_EN
    .last_owner_i (last_owner_q),
`endif
    .pick_o       (pick)
  );

  // Read data is broadcast; each side qualifies it with its ready.
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign grant_d    = (state_q == OWN_D);

  always_comb begin
    state_d    = state_q;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_write  = 1'b0;
    mem_wdata  = '0;
    mem_wstrb  = {STRB_W{1'b0}};
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = pick;
      end
      OWN_I: begin
        mem_valid  = imem_valid;
        mem_addr   = imem_addr;
        imem_ready = mem_ready & imem_valid;
        // Dropped valid aborts the grant without a ready.
        if (!imem_valid || mem_ready) begin
          state_d = IDLE;
        end
      end
      OWN_D: begin
        mem_valid  = dmem_valid;
        mem_addr   = dmem_addr;
        mem_write  = dmem_write;
        mem_wdata  = dmem_wdata;
        mem_wstrb  = dmem_wstrb;
        dmem_ready = mem_ready & dmem_valid;
        if (!dmem_valid || mem_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CORE_MEM_ARB_RR_EN
  always_comb begin
    last_owner_d = last_owner_q;
    if (mem_valid && mem_ready) begin
      last_owner_d = (state_q == OWN_D);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed vector table,
// randomized run against a transaction-level model, and tie policy.
module tb_core_mem_arbiter;

`ifdef CORE_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_valid, dmem_ready;
  logic [31:0] dmem_addr;
  logic        dmem_write;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        grant_d;

  always #5 clk = ~clk;

  core_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_valid (imem_valid),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_valid (dmem_valid),
    .dmem_ready (dmem_ready),
    .dmem_addr  (dmem_addr),
    .dmem_write (dmem_write),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_rdata (dmem_rdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .grant_d    (grant_d)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic        dw;
    logic [31:0] dwd;
    logic [3:0]  ds;
    logic        mr;
    logic [31:0] mrd;
    logic        e_mv;
    logic [31:0] e_ma;
    logic        e_mw;
    logic [31:0] e_mwd;
    logic [3:0]  e_ms;
    logic        e_ir, e_dr, e_gd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    logic r, logic iv, logic [31:0] ia, logic dv, logic [31:0] da,
    logic dw, logic [31:0] dwd, logic [3:0] ds, logic mr,
    logic [31:0] mrd, logic e_mv, logic [31:0] e_ma, logic e_mw,
    logic [31:0] e_mwd, logic [3:0] e_ms, logic e_ir, logic e_dr,
    logic e_gd);
    vec_t x;
    x.rst = r;  x.iv = iv;  x.ia = ia;  x.dv = dv;  x.da = da;
    x.dw = dw;  x.dwd = dwd; x.ds = ds; x.mr = mr;  x.mrd = mrd;
    x.e_mv = e_mv; x.e_ma = e_ma; x.e_mw = e_mw; x.e_mwd = e_mwd;
    x.e_ms = e_ms; x.e_ir = e_ir; x.e_dr = e_dr; x.e_gd = e_gd;
    return x;
  endfunction

  // Transaction-level model: who holds the bus, who was served last.
  int m_own  = 0;  // 0 none, 1 imem, 2 dmem
  bit m_last = 0;  // 1 = dmem served last

  task automatic model_update();
    if (rst) begin
      m_own  = 0;
      m_last = 0;
    end else if (m_own == 0) begin
      if (imem_valid && dmem_valid) m_own = (RR && m_last) ? 1 : 2;
      else if (dmem_valid) m_own = 2;
      else if (imem_valid) m_own = 1;
    end else begin
      logic ov;
      ov = (m_own == 1) ? imem_valid : dmem_valid;
      if (ov && mem_ready) m_last = (m_own == 2);
      if (!ov || mem_ready) m_own = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input vec_t x);
    rst = x.rst; imem_valid = x.iv; imem_addr = x.ia;
    dmem_valid = x.dv; dmem_addr = x.da; dmem_write = x.dw;
    dmem_wdata = x.dwd; dmem_wstrb = x.ds;
    mem_ready = x.mr; mem_rdata = x.mrd;
  endtask

  task automatic model_check(input int c);
    bit oi, od;
    oi = (m_own == 1);
    od = (m_own == 2);
    chk($sformatf("rnd%0d mem_valid", c), mem_valid,
        (oi && imem_valid) || (od && dmem_valid));
    chk($sformatf("rnd%0d mem_addr", c), mem_addr,
        oi ? imem_addr : od ? dmem_addr : 32'h0);
    chk($sformatf("rnd%0d mem_write", c), mem_write, od && dmem_write);
    chk($sformatf("rnd%0d mem_wdata", c), mem_wdata,
        od ? dmem_wdata : 32'h0);
    chk($sformatf("rnd%0d mem_wstrb", c), mem_wstrb,
        od ? dmem_wstrb : 4'h0);
    chk($sformatf("rnd%0d imem_ready", c), imem_ready,
        oi && imem_valid && mem_ready);
    chk($sformatf("rnd%0d dmem_ready", c), dmem_ready,
        od && dmem_valid && mem_ready);
    chk($sformatf("rnd%0d grant_d", c), grant_d, od);
    chk($sformatf("rnd%0d imem_rdata", c), imem_rdata, mem_rdata);
    chk($sformatf("rnd%0d dmem_rdata", c), dmem_rdata, mem_rdata);
  endtask

  initial begin
    bit g[$];

    // Idle request: iv/dv 0, OWN_* outputs zero.
    drive(v(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    tick();
    tick();

    // Reset state (rst held)
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    // Fetch 0x100 with mem_ready high
    tbl.push_back(v(0,1,32'h100,0,0,0,0,0,1,32'h13,
                    0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,32'h100,0,0,0,0,0,1,32'h13,
                    1,32'h100,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,32'h13, 0,0,0,0,0,0,0,0));
    // Simultaneous requests: dmem store first, bubble, then imem
    tbl.push_back(v(0,1,32'h104,1,32'h200,1,32'hDEADBEEF,4'hF,1,32'h1,
                    0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,32'h104,1,32'h200,1,32'hDEADBEEF,4'hF,1,32'h2,
                    1,32'h200,1,32'hDEADBEEF,4'hF,0,1,1));
    tbl.push_back(v(0,1,32'h104,0,0,0,0,0,1,32'h3, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,32'h104,0,0,0,0,0,1,32'h4,
                    1,32'h104,0,0,0,1,0,0));
    // dmem load stalled 5 cycles while imem waits
    tbl.push_back(v(0,0,0,1,32'h300,0,0,0,0,32'h5, 0,0,0,0,0,0,0,0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(v(0,1,32'h108,1,32'h300,0,0,0,0,32'h6,
                      1,32'h300,0,0,0,0,0,1));
    tbl.push_back(v(0,1,32'h108,1,32'h300,0,0,0,1,32'h7,
                    1,32'h300,0,0,0,0,1,1));
    tbl.push_back(v(0,1,32'h108,0,0,0,0,0,1,32'h8, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,32'h108,0,0,0,0,0,1,32'h9,
                    1,32'h108,0,0,0,1,0,0));
    // Reset mid OWN_I, then pending dmem wins
    tbl.push_back(v(0,1,32'h10C,0,0,0,0,0,0,32'hA, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,32'h10C,0,0,0,0,0,0,32'hB,
                    1,32'h10C,0,0,0,0,0,0));
    tbl.push_back(v(1,1,32'h10C,1,32'h400,1,32'h55,4'h3,0,32'hC,
                    1,32'h10C,0,0,0,0,0,0));
    tbl.push_back(v(0,1,32'h10C,1,32'h400,1,32'h55,4'h3,0,32'hD,
                    0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,32'h10C,1,32'h400,1,32'h55,4'h3,1,32'hE,
                    1,32'h400,1,32'h55,4'h3,0,1,1));
    // dmem drops valid mid-grant
    tbl.push_back(v(0,0,0,1,32'h500,0,0,0,0,32'hF, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,1,32'h500,0,0,0,0,32'h10,
                    1,32'h500,0,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,32'h500,0,0,0,1,32'h11,
                    0,32'h500,0,0,0,0,0,1));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,32'h12, 0,0,0,0,0,0,0,0));

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k]);
      @(negedge clk);
      chk($sformatf("r%0d mem_valid", k), mem_valid, tbl[k].e_mv);
      chk($sformatf("r%0d mem_addr", k), mem_addr, tbl[k].e_ma);
      chk($sformatf("r%0d mem_write", k), mem_write, tbl[k].e_mw);
      chk($sformatf("r%0d mem_wdata", k), mem_wdata, tbl[k].e_mwd);
      chk($sformatf("r%0d mem_wstrb", k), mem_wstrb, tbl[k].e_ms);
      chk($sformatf("r%0d imem_ready", k), imem_ready, tbl[k].e_ir);
      chk($sformatf("r%0d dmem_ready", k), dmem_ready, tbl[k].e_dr);
      chk($sformatf("r%0d grant_d", k), grant_d, tbl[k].e_gd);
      chk($sformatf("r%0d imem_rdata", k), imem_rdata, tbl[k].mrd);
      tick();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 49) == 0);
      imem_valid = ($urandom_range(0, 3) != 0);
      dmem_valid = ($urandom_range(0, 2) != 0);
      imem_addr  = $urandom;
      dmem_addr  = $urandom;
      dmem_write = $urandom_range(0, 1);
      dmem_wdata = $urandom;
      dmem_wstrb = 4'($urandom_range(0, 15));
      mem_ready  = ($urandom_range(0, 2) != 0);
      mem_rdata  = $urandom;
      @(negedge clk);
      model_check(c);
      tick();
    end

    // Tie policy with both requesters always valid
    drive(v(1,1,32'h600,1,32'h700,0,0,0,1,0, 0,0,0,0,0,0,0,0));
    tick();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_valid && mem_ready) g.push_back(grant_d);
      tick();
    end
    chk("tie grant count", g.size(), 6);
    for (int k = 0; k < g.size(); k++) begin
      chk($sformatf("tie grant %0d owner_d", k), g[k],
          RR ? ((k % 2) == 0) : 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
